// File: rtl/latch_mon_pkg.sv
// Shared types and parameter defaults for the latch output monitor.
package latch_mon_pkg;

    localparam int STABLE_CYC_DEF = 2;
    localparam int CNT_W_DEF      = 8;

    typedef enum logic [1:0] {
        S_LOW      = 2'd0,
        S_RISE_CHK = 2'd1,
        S_HIGH     = 2'd2,
        S_FALL_CHK = 2'd3
    } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer with a parameterized reset level.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/latch_mon.sv
// Monitors a latch's q/qb pair: synchronizes, debounces q, counts accepted
// edges and flags loss of complementarity between q and qb.
module latch_mon
    import latch_mon_pkg::*;
#(
    parameter int STABLE_CYC = STABLE_CYC_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             q_in,
    input  logic             qb_in,
    input  logic             clr,
    output logic             q_filt,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             cmp_err,
    output logic [1:0]       o_dbg_state
);

    localparam logic [3:0]       STAB_LAST = 4'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic w_q_sync;
    logic w_qb_sync;
    logic w_eq;

    state_t           r_state;
    logic [3:0]       r_stab;
    logic             r_q_filt;
    logic             r_rise;
    logic             r_fall;
    logic [CNT_W-1:0] r_edge_cnt;
    logic             r_cmp_err;
    logic             r_eq_d;

    // qb idles high so a freshly reset pair reads as complementary.
    sync2 #(.RST_VAL(1'b0)) u_sync_q (
        .clk (clk),
        .rst (rst),
        .i_d (q_in),
        .o_q (w_q_sync)
    );

    sync2 #(.RST_VAL(1'b1)) u_sync_qb (
        .clk (clk),
        .rst (rst),
        .i_d (qb_in),
        .o_q (w_qb_sync)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_LOW;
            r_stab   <= 4'd0;
            r_q_filt <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                S_LOW: begin
                    if (w_q_sync) begin
                        if (STABLE_CYC == 1) begin
                            r_state  <= S_HIGH;
                            r_q_filt <= 1'b1;
                            r_rise   <= 1'b1;
                            r_stab   <= 4'd0;
                        end else begin
                            r_state <= S_RISE_CHK;
                            r_stab  <= 4'd1;
                        end
                    end
                end
                S_RISE_CHK: begin
                    if (!w_q_sync) begin
                        r_state <= S_LOW;
                        r_stab  <= 4'd0;
                    end else if (r_stab == STAB_LAST) begin
                        r_state  <= S_HIGH;
                        r_q_filt <= 1'b1;
                        r_rise   <= 1'b1;
                        r_stab   <= 4'd0;
                    end else begin
                        r_stab <= r_stab + 4'd1;
                    end
                end
                S_HIGH: begin
                    if (!w_q_sync) begin
                        if (STABLE_CYC == 1) begin
                            r_state  <= S_LOW;
                            r_q_filt <= 1'b0;
                            r_fall   <= 1'b1;
                            r_stab   <= 4'd0;
                        end else begin
                            r_state <= S_FALL_CHK;
                            r_stab  <= 4'd1;
                        end
                    end
                end
                S_FALL_CHK: begin
                    if (w_q_sync) begin
                        r_state <= S_HIGH;
                        r_stab  <= 4'd0;
                    end else if (r_stab == STAB_LAST) begin
                        r_state  <= S_LOW;
                        r_q_filt <= 1'b0;
                        r_fall   <= 1'b1;
                        r_stab   <= 4'd0;
                    end else begin
                        r_stab <= r_stab + 4'd1;
                    end
                end
            endcase
        end
    end

    assign w_eq = (w_q_sync == w_qb_sync);

    // Counter and error flag see the registered pulses, so a clr landing in
    // the pulse cycle still leaves them at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_edge_cnt <= '0;
            r_cmp_err  <= 1'b0;
            r_eq_d     <= 1'b0;
        end else begin
            r_eq_d <= w_eq;
            if (clr) begin
                r_edge_cnt <= '0;
                r_cmp_err  <= 1'b0;
            end else begin
                if ((r_rise || r_fall) && (r_edge_cnt != CNT_MAX)) begin
                    r_edge_cnt <= r_edge_cnt + CNT_ONE;
                end
                if (w_eq && r_eq_d) begin
                    r_cmp_err <= 1'b1;
                end
            end
        end
    end

    assign q_filt      = r_q_filt;
    assign rise_pulse  = r_rise;
    assign fall_pulse  = r_fall;
    assign edge_cnt    = r_edge_cnt;
    assign cmp_err     = r_cmp_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_latch_mon.sv
// Self-checking bench for latch_mon: a run-length reference model feeds an
// expected queue compared every cycle, plus directed scenario checks.
module tb_latch_mon;

    localparam int STABLE_CYC = 2;
    localparam int CNT_W      = 8;
    localparam int W          = CNT_W + 4;

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             q_in  = 1'b0;
    logic             qb_in = 1'b1;
    logic             clr   = 1'b0;
    logic             q_filt;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] edge_cnt;
    logic             cmp_err;
    logic [1:0]       dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] exp_q[$];

    latch_mon #(
        .STABLE_CYC (STABLE_CYC),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .q_in        (q_in),
        .qb_in       (qb_in),
        .clr         (clr),
        .q_filt      (q_filt),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .edge_cnt    (edge_cnt),
        .cmp_err     (cmp_err),
        .o_dbg_state (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // reference model: q_filt flips once the synchronized level has differed
    // from it for STABLE_CYC consecutive edges
    logic             m_s1 = 1'b0, m_s2 = 1'b0, m_b1 = 1'b1, m_b2 = 1'b1;
    logic             m_filt = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
    logic             m_err = 1'b0, m_eq_prev = 1'b0;
    logic [CNT_W-1:0] m_cnt = '0;
    int               m_run = 0;

    always @(posedge clk) begin
        logic eq;
        if (rst) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_b1 = 1'b1; m_b2 = 1'b1;
            m_filt = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
            m_err = 1'b0; m_eq_prev = 1'b0; m_cnt = '0; m_run = 0;
        end else begin
            eq = (m_s2 == m_b2);
            if (clr) begin
                m_cnt = '0;
                m_err = 1'b0;
            end else begin
                if ((m_rise || m_fall) && m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
                if (eq && m_eq_prev) m_err = 1'b1;
            end
            m_eq_prev = eq;
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (m_s2 != m_filt) m_run = m_run + 1;
            else m_run = 0;
            if (m_run == STABLE_CYC) begin
                m_filt = ~m_filt;
                m_rise = m_filt;
                m_fall = ~m_filt;
                m_run  = 0;
            end
            m_s2 = m_s1; m_s1 = q_in;
            m_b2 = m_b1; m_b1 = qb_in;
        end
        exp_q.push_back({m_filt, m_rise, m_fall, m_err, m_cnt});
    end

    // scoreboard
    always @(negedge clk) begin
        logic [W-1:0] exp;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check("sb", {20'd0, q_filt, rise_pulse, fall_pulse, cmp_err, edge_cnt}, {20'd0, exp});
        end
    end

    task automatic wait_pulse(input string tag, input bit want_rise, input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (want_rise ? rise_pulse : fall_pulse) seen = 1'b1;
        end
        check(tag, seen, 1);
    endtask

    task automatic set_q(input logic v);
        q_in  = v;
        qb_in = ~v;
    endtask

    initial begin
        bit any;
        rst = 1'b1;
        set_q(1'b0);
        repeat (3) @(negedge clk);
        check("rst_outs", {q_filt, rise_pulse, fall_pulse, cmp_err, edge_cnt}, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_state", dbg_state, 0);
        check("idle_outs", {q_filt, rise_pulse, fall_pulse, cmp_err, edge_cnt}, 0);

        // first accepted rise: visible after the fourth sampling edge
        set_q(1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("rise_filt", q_filt, 1);
        check("rise_pulse", rise_pulse, 1);
        @(posedge clk);
        #1;
        check("rise_cnt", edge_cnt, 1);
        check("rise_err", cmp_err, 0);

        @(negedge clk);
        set_q(1'b0);
        wait_pulse("fall_seen", 1'b0, 20);
        repeat (4) @(negedge clk);

        // one-cycle glitch must be filtered
        set_q(1'b1);
        @(negedge clk);
        set_q(1'b0);
        any = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            any |= rise_pulse | q_filt;
        end
        check("glitch_none", any, 0);
        check("glitch_cnt", edge_cnt, 2);

        // q == qb for three cycles
        q_in  = 1'b1;
        qb_in = 1'b1;
        repeat (3) @(negedge clk);
        set_q(1'b0);
        repeat (10) @(negedge clk);
        check("err_sticky", cmp_err, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_err", cmp_err, 0);
        check("clr_cnt", edge_cnt, 0);

        // reset in the middle of a rise check
        set_q(1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("in_rise_chk", dbg_state, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_abort_outs", {q_filt, rise_pulse, fall_pulse, cmp_err, edge_cnt}, 0);
        check("rst_abort_state", dbg_state, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_pulse("post_rst_rise", 1'b1, 20);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;

        // clr coinciding with a rise pulse at edge_cnt == 5
        for (int k = 0; k < 5; k++) begin
            set_q(k[0] ? 1'b1 : 1'b0);
            wait_pulse("toggle", k[0], 20);
            repeat (3) @(negedge clk);
        end
        set_q(1'b1);
        wait_pulse("rise6", 1'b1, 20);
        check("cnt5", edge_cnt, 5);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_wins", edge_cnt, 0);

        // random levels, occasionally non-complementary
        for (int i = 0; i < 40; i++) begin
            q_in  = 1'($urandom_range(0, 1));
            qb_in = ($urandom_range(0, 7) == 0) ? q_in : ~q_in;
            repeat ($urandom_range(1, 6)) @(negedge clk);
        end
        set_q(1'b0);
        repeat (10) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (2) @(negedge clk);

        // saturation over 300 accepted edges
        for (int i = 0; i < 300; i++) begin
            set_q(i[0] ? 1'b0 : 1'b1);
            repeat (8) @(negedge clk);
        end
        check("sat_cnt", edge_cnt, 255);
        set_q(1'b1);
        wait_pulse("sat_pulse", 1'b1, 20);
        @(negedge clk);
        check("sat_hold", edge_cnt, 255);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
